uart_crc_receiver: RTL
======================

Name: uart_crc_receiver

Overview:
- Serial receiver directly downstream of the UART CRC transmitter.
- Recovers the 18-bit frame: start bit (0), data byte LSB first, CRC byte LSB first, stop bit (1).
- Recomputes CRC-8 over the received data byte and flags any mismatch.
- Presents data, received CRC and status as single-cycle pulses to the downstream consumer (display/debug logic).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate; BIT_PERIOD = CLK_FREQ/BAUD_RATE clocks (5208 at defaults), HALF_PERIOD = BIT_PERIOD/2
CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1); init 0x00, no reflection, no final XOR, data processed MSB first

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
rx_in  input  1  serial line, asynchronous to clk, idle high
data_out  output  8  last good-framed data byte
crc_out  output  8  CRC byte received with data_out
data_valid  output  1  one-cycle pulse: data_out/crc_out updated
crc_error  output  1  one-cycle pulse coincident with data_valid when CRC_8(data_out) != crc_out
frame_error  output  1  one-cycle pulse: stop bit sampled 0
rx_busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (reset_n=0, async):
  - FSM to IDLE.
  - data_out=0x00, crc_out=0x00, data_valid=0, crc_error=0, frame_error=0, rx_busy=0.
  - Synchronizer flops=1; counters=0.
- rx_in passes through a 2-flop synchronizer (rx_s) before any use; adds 2 cycles latency.
- Baud counter width: $clog2(BIT_PERIOD). Bit index: 0..15.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: rx_s==0 -> START; baud_cnt=0.
  - START: count to HALF_PERIOD-1, then sample rx_s.
    - rx_s==0: go to DATA; baud_cnt=0, bit_idx=0.
    - rx_s==1 (glitch/false start): go to IDLE; no output pulses.
  - DATA: at baud_cnt==BIT_PERIOD-1, sample rx_s into 16-bit shift reg (shift right, new bit enters MSB), bit_idx++, baud_cnt=0.
    - After the 16th sample: shift[7:0]=data, shift[15:8]=crc. Go to STOP.
  - STOP: at baud_cnt==BIT_PERIOD-1, sample rx_s.
    - rx_s==1: load data_out/crc_out; pulse data_valid; pulse crc_error if mismatch; go to IDLE.
    - rx_s==0: pulse frame_error; data_out/crc_out unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. Prevents a held-low line (break) retriggering frames.
- CRC_8 computed combinationally over the assembled data byte (MSB first) in the STOP sample cycle; no extra latency.
- All status outputs are registered pulses, high exactly one clk; crc_error=0 whenever data_valid=0.
- Latency from rx_in falling edge to data_valid: 2 + HALF_PERIOD + 17*BIT_PERIOD clocks, ±1.
- Sampling is at mid-bit, so back-to-back frames are accepted: IDLE is re-entered half a bit before the stop bit ends, and the next start edge is detected normally.
- reset_n asserted mid-frame: immediate abort and all outputs cleared. No pulse is generated for the partial frame after release.
- No backpressure: the consumer must capture data_out on data_valid. The next frame overwrites data_out.

Test Plan (CLK_FREQ=160, BAUD_RATE=10 -> 16 clk/bit, HALF=8):
1. Send data 0xA5, crc 0x72 (correct CRC-8) -> exactly one data_valid pulse; data_out=0xA5, crc_out=0x72; crc_error=0; frame_error=0; rx_busy low after.
2. Send data 0xA5, crc 0x73 -> data_valid with crc_error=1 in the same cycle; data_out=0xA5, crc_out=0x73.
3. Send data 0x01, crc 0x07 with stop bit 0, then hold rx_in low 100 clks -> one frame_error pulse; no data_valid; data_out keeps its previous value; rx_busy stays high until rx_in returns high; no further pulses.
4. Drive a 4-clk low glitch on idle rx_in -> no pulses on any output; rx_busy returns to 0 within HALF+3 clks.
5. Assert reset_n low during data bit 5 of a frame, release, then send 0x01/0x07 -> outputs 0 while in reset; no pulse from the aborted frame; second frame gives data_out=0x01, crc_out=0x07, crc_error=0.
6. Back-to-back frames 0x00/0x00 then 0x01/0x07 with no idle gap -> two data_valid pulses 18*16 clks apart (±1), both with crc_error=0.

Source files
------------

// File: rtl/uart_crc_receiver.sv
// rtl/uart_crc_receiver.sv - UART frame receiver with CRC-8 check of the data byte
// Frame on the line: start(0), data LSB first, crc LSB first, stop(1); sampled at mid-bit.
module uart_crc_receiver #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD_RATE = 9600,
  parameter logic [7:0] CRC_POLY  = 8'h07
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic [7:0] crc_out,
  output logic       data_valid,
  output logic       crc_error,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, cnt_next;
  logic [3:0]       bit_idx, idx_next;
  logic [15:0]      shift, shift_next;
  logic [7:0]       data_next, crc_next;
  logic             dv_next, ce_next, fe_next;
  logic             rx_meta, rx_s;

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      crc_out     <= '0;
      data_valid  <= 1'b0;
      crc_error   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      baud_cnt    <= cnt_next;
      bit_idx     <= idx_next;
      shift       <= shift_next;
      data_out    <= data_next;
      crc_out     <= crc_next;
      data_valid  <= dv_next;
      crc_error   <= ce_next;
      frame_error <= fe_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = baud_cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    data_next  = data_out;
    crc_next   = crc_out;
    dv_next    = 1'b0;
    ce_next    = 1'b0;
    fe_next    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // a start bit that is no longer low at mid-bit was a glitch
        if (baud_cnt == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift[15:1]};
          idx_next   = bit_idx + 1'b1;
          if (bit_idx == 4'd15) state_next = STOP;
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift[7:0];
            crc_next   = shift[15:8];
            dv_next    = 1'b1;
            ce_next    = (crc8(shift[7:0]) != shift[15:8]);
            state_next = IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = baud_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // a line held low (break) must return high before a new frame can start
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule
